// File: rtl/dcache_ctrl.sv
// -----------------------------------------------------------------------------
// dcache_ctrl
//   Controller for a write-back, write-allocate, direct-mapped data cache. It
//   sequences the D-cache tag/data SRAM from the CPU side and moves whole blocks
//   to and from main memory. Only one request is in flight at a time.
//
// Ports
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   cpu_*             CPU request (req/wen/addr/be/wdata) and response (ready/rdata)
//   sram_*            D-cache SRAM control (en/wen/dmem_wen/bytes/block_addr/wdata)
//                     and its combinational lookup results (hit/dirty/victim_tag/rdata)
//   mem_*             main-memory block port (req/wen/addr/wdata, ready/rdata)
//
// Sequence: IDLE latches the request, LOOKUP probes the SRAM, a dirty miss
// goes through WRITEBACK, every miss goes through REFILL and INSTALL, and
// INSTALL replays the request in LOOKUP, where it is then a guaranteed hit.
// -----------------------------------------------------------------------------
module dcache_ctrl #(
    parameter  int TAG_W       = 22,
    parameter  int INDEX_W     = 6,
    parameter  int OFF_W       = 4,
    localparam int BLOCK_BYTES = 2 ** OFF_W,
    localparam int BLOCK_BITS  = 8 * BLOCK_BYTES,
    localparam int BADDR_W     = TAG_W + INDEX_W,
    localparam int WORD_W      = OFF_W - 2
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cpu_req,
    input  logic                   cpu_wen,
    input  logic [31:0]            cpu_addr,
    input  logic [3:0]             cpu_be,
    input  logic [31:0]            cpu_wdata,
    output logic                   cpu_ready,
    output logic [31:0]            cpu_rdata,

    output logic                   sram_en,
    output logic                   sram_wen,
    output logic                   sram_dmem_wen,
    output logic [BLOCK_BYTES-1:0] sram_bytes,
    output logic [BADDR_W-1:0]     sram_block_addr,
    output logic [BLOCK_BITS-1:0]  sram_wdata,
    input  logic                   sram_hit,
    input  logic                   sram_dirty,
    input  logic [TAG_W-1:0]       sram_victim_tag,
    input  logic [BLOCK_BITS-1:0]  sram_rdata,

    output logic                   mem_req,
    output logic                   mem_wen,
    output logic [BADDR_W-1:0]     mem_addr,
    output logic [BLOCK_BITS-1:0]  mem_wdata,
    input  logic                   mem_ready,
    input  logic [BLOCK_BITS-1:0]  mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WRITEBACK,
        S_REFILL,
        S_INSTALL
    } state_t;

    state_t                  state_q,  state_d;
    logic [BADDR_W-1:0]      blk_q,    blk_d;      // latched {tag,index}
    logic [WORD_W-1:0]       word_q,   word_d;     // latched word within block
    logic                    wen_q,    wen_d;
    logic [3:0]              be_q,     be_d;
    logic [31:0]             wdata_q,  wdata_d;
    logic [TAG_W-1:0]        victim_q, victim_d;
    // One line buffer serves both directions: it holds the victim during
    // WRITEBACK and the fetched block during INSTALL, never both at once.
    logic [BLOCK_BITS-1:0]   line_q,   line_d;

    // Word accesses only; the two lowest address bits carry no information.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr[1:0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            blk_q    <= '0;
            word_q   <= '0;
            wen_q    <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            victim_q <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            word_q   <= word_d;
            wen_q    <= wen_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            victim_q <= victim_d;
            line_q   <= line_d;
        end
    end

    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d         = state_q;
        blk_d           = blk_q;
        word_d          = word_q;
        wen_d           = wen_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        victim_d        = victim_q;
        line_d          = line_q;

        cpu_ready       = 1'b0;
        cpu_rdata       = '0;
        sram_en         = 1'b0;
        sram_wen        = 1'b0;
        sram_dmem_wen   = 1'b0;
        sram_bytes      = '0;
        sram_block_addr = '0;
        sram_wdata      = '0;
        mem_req         = 1'b0;
        mem_wen         = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    blk_d   = cpu_addr[31:OFF_W];
                    word_d  = cpu_addr[OFF_W-1:2];
                    wen_d   = cpu_wen;
                    be_d    = cpu_be;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end

            S_LOOKUP: begin
                sram_en         = 1'b1;
                sram_block_addr = blk_q;
                if (sram_hit) begin
                    cpu_ready = 1'b1;
                    state_d   = S_IDLE;
                    if (wen_q) begin
                        // Store merges into the line in the same cycle; the
                        // word is replicated and the byte mask picks the lane.
                        sram_wen   = 1'b1;
                        sram_bytes = BLOCK_BYTES'(be_q) << {word_q, 2'b00};
                        sram_wdata = {(BLOCK_BITS / 32){wdata_q}};
                    end else begin
                        cpu_rdata = sram_rdata[{word_q, 5'b00000} +: 32];
                    end
                end else if (sram_dirty) begin
                    line_d   = sram_rdata;
                    victim_d = sram_victim_tag;
                    state_d  = S_WRITEBACK;
                end else begin
                    state_d = S_REFILL;
                end
            end

            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_wen   = 1'b1;
                mem_addr  = {victim_q, blk_q[INDEX_W-1:0]};
                mem_wdata = line_q;
                if (mem_ready) begin
                    state_d = S_REFILL;
                end
            end

            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = blk_q;
                if (mem_ready) begin
                    line_d  = mem_rdata;
                    state_d = S_INSTALL;
                end
            end

            S_INSTALL: begin
                // Full-block write that also sets the tag and clears dirty;
                // the replayed LOOKUP then serves the original request.
                sram_en         = 1'b1;
                sram_wen        = 1'b1;
                sram_dmem_wen   = 1'b1;
                sram_bytes      = '1;
                sram_block_addr = blk_q;
                sram_wdata      = line_q;
                state_d         = S_LOOKUP;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dcache_ctrl
//   Directed bench for dcache_ctrl. A behavioural D-cache SRAM (tag/valid/dirty/
//   data per set) answers the controller's lookups; main memory is played by the
//   request task, which raises mem_ready after a chosen number of cycles.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dcache_ctrl;

    localparam int TAG_W   = 22;
    localparam int INDEX_W = 6;
    localparam int OFF_W   = 4;
    localparam int SETS    = 2 ** INDEX_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_wen, cpu_ready;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]   cpu_be;
    logic         sram_en, sram_wen, sram_dmem_wen, sram_hit, sram_dirty;
    logic [15:0]  sram_bytes;
    logic [27:0]  sram_block_addr;
    logic [127:0] sram_wdata, sram_rdata;
    logic [21:0]  sram_victim_tag;
    logic         mem_req, mem_wen, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    dcache_ctrl #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFF_W(OFF_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cpu_req         (cpu_req),
        .cpu_wen         (cpu_wen),
        .cpu_addr        (cpu_addr),
        .cpu_be          (cpu_be),
        .cpu_wdata       (cpu_wdata),
        .cpu_ready       (cpu_ready),
        .cpu_rdata       (cpu_rdata),
        .sram_en         (sram_en),
        .sram_wen        (sram_wen),
        .sram_dmem_wen   (sram_dmem_wen),
        .sram_bytes      (sram_bytes),
        .sram_block_addr (sram_block_addr),
        .sram_wdata      (sram_wdata),
        .sram_hit        (sram_hit),
        .sram_dirty      (sram_dirty),
        .sram_victim_tag (sram_victim_tag),
        .sram_rdata      (sram_rdata),
        .mem_req         (mem_req),
        .mem_wen         (mem_wen),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural D-cache SRAM ----------------
    logic [21:0]  m_tag   [SETS];
    logic         m_valid [SETS];
    logic         m_dirty [SETS];
    logic [127:0] m_data  [SETS];
    logic [5:0]   m_idx;
    int           wr_count = 0;

    assign m_idx           = sram_block_addr[5:0];
    assign sram_hit        = m_valid[m_idx] && (m_tag[m_idx] == sram_block_addr[27:6]);
    assign sram_dirty      = m_valid[m_idx] && m_dirty[m_idx];
    assign sram_victim_tag = m_tag[m_idx];
    assign sram_rdata      = m_data[m_idx];

    // NOTE: only the valid bits are cleared on reset; tag, dirty and data
    // arrays are don't-care until a line has been installed.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) m_valid[s] <= 1'b0;
        end else if (sram_en && sram_wen) begin
            wr_count <= wr_count + 1;
            if (sram_dmem_wen) begin
                m_tag[m_idx]   <= sram_block_addr[27:6];
                m_valid[m_idx] <= 1'b1;
                m_dirty[m_idx] <= 1'b0;
                m_data[m_idx]  <= sram_wdata;
            end else begin
                m_dirty[m_idx] <= 1'b1;
                for (int b = 0; b < 16; b++)
                    if (sram_bytes[b]) m_data[m_idx][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- per-request observation log ----------------
    logic         wb_seen, rf_seen;
    logic [27:0]  wb_addr, rf_addr;
    logic [127:0] wb_data;
    int           n_install, n_cpu_wr;
    logic [15:0]  last_bytes;
    logic [127:0] last_wdata;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one CPU request at a falling edge and play main memory until the
    // controller answers. edges counts rising edges from the sampling edge to
    // the cycle where cpu_ready is seen. Ends one cycle later with the DUT idle.
    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int wb_lat, input int rf_lat,
                          input logic [127:0] fill, output int edges,
                          output logic [31:0] rdata, output logic got);
        int wb_cnt = 0;
        int rf_cnt = 0;
        cpu_req   = 1'b1;
        cpu_wen   = wen;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = wdata;
        edges     = 0;
        got       = 1'b0;
        rdata     = '0;
        wb_seen   = 1'b0;
        rf_seen   = 1'b0;
        n_install = 0;
        n_cpu_wr  = 0;
        while (!got && edges < 100) begin
            @(negedge clk);
            edges++;
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (sram_en && sram_wen) begin
                if (sram_dmem_wen) n_install++;
                else begin
                    n_cpu_wr++;
                    last_bytes = sram_bytes;
                    last_wdata = sram_wdata;
                end
            end
            if (cpu_ready) begin
                got     = 1'b1;
                rdata   = cpu_rdata;
                cpu_req = 1'b0;
            end else if (mem_req && mem_wen) begin
                wb_cnt++;
                wb_seen = 1'b1;
                wb_addr = mem_addr;
                wb_data = mem_wdata;
                if (wb_cnt == wb_lat) mem_ready = 1'b1;
            end else if (mem_req) begin
                rf_cnt++;
                rf_seen = 1'b1;
                rf_addr = mem_addr;
                if (rf_cnt == rf_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = fill;
                end
            end
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    localparam logic [127:0] FILL0 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
    localparam logic [127:0] FILL1 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] FILL2 = 128'h44444444_33333333_22222222_11111111;

    initial begin
        int          edges;
        logic [31:0] rdata;
        logic        got;
        logic        found;
        int          wr_before;
        int          pulses;

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_wen   = 1'b0;
        cpu_addr  = '0;
        cpu_be    = '0;
        cpu_wdata = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        repeat (2) @(negedge clk);

        // ---- reset state ----
        check("rst_cpu_ready",  128'(cpu_ready), 128'd0);
        check("rst_cpu_rdata",  128'(cpu_rdata), 128'd0);
        check("rst_sram_en",    128'(sram_en), 128'd0);
        check("rst_sram_addr",  128'(sram_block_addr), 128'd0);
        check("rst_mem_req",    128'(mem_req), 128'd0);
        check("rst_mem_addr",   128'(mem_addr), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // ---- 1: reset in the middle of a refill ----
        cpu_req  = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 32'h0000_2040;
        found    = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (mem_req && !mem_wen) found = 1'b1;
        end
        check("t1_reach_refill", 128'(found), 128'd1);
        cpu_req   = 1'b0;
        wr_before = wr_count;
        rst       = 1'b1;
        #1;
        check("t1_mem_req_drop", 128'(mem_req), 128'd0);
        check("t1_sram_en_drop", 128'(sram_en), 128'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        check("t1_mem_req_held_low", 128'(mem_req), 128'd0);
        mem_ready = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("t1_no_sram_write", 128'(wr_count), 128'(wr_before));
        check("t1_idle_no_ready", 128'(cpu_ready), 128'd0);
        check("t1_idle_no_mem",   128'(mem_req), 128'd0);

        // ---- 2: cold load, refill after 3 cycles: 1+3+2 = 6 edges ----
        do_req(1'b0, 32'h0000_0010, 4'h0, 32'h0, 0, 3, FILL0, edges, rdata, got);
        check("t2_got",        128'(got), 128'd1);
        check("t2_latency",    128'(edges), 128'd6);
        check("t2_rdata",      128'(rdata), 128'h3322_1100);
        check("t2_installs",   128'(n_install), 128'd1);
        check("t2_rf_addr",    128'(rf_addr), 128'h000_0001);
        check("t2_no_wb",      128'(wb_seen), 128'd0);
        check("t2_clean_line", 128'(m_dirty[1]), 128'd0);

        // ---- 3: store hit to word 2, byte 1 ----
        do_req(1'b1, 32'h0000_0018, 4'b0010, 32'hAABB_CCDD, 0, 1, '0, edges, rdata, got);
        check("t3_latency",    128'(edges), 128'd1);
        check("t3_cpu_writes", 128'(n_cpu_wr), 128'd1);
        check("t3_installs",   128'(n_install), 128'd0);
        check("t3_bytes",      128'(last_bytes), 128'h0200);
        check("t3_wdata",      last_wdata, {4{32'hAABB_CCDD}});
        check("t3_no_mem",     128'({wb_seen, rf_seen}), 128'd0);
        do_req(1'b0, 32'h0000_0018, 4'h0, 32'h0, 0, 1, '0, edges, rdata, got);
        check("t3_reload_lat", 128'(edges), 128'd1);
        check("t3_reload",     128'(rdata), 128'hBBAA_CC88);
        do_req(1'b0, 32'h0000_001C, 4'h0, 32'h0, 0, 1, '0, edges, rdata, got);
        check("t3_other_word", 128'(rdata), 128'hFFEE_DDCC);

        // ---- 4: dirty conflict miss: 1+2+2+2 = 7 edges ----
        do_req(1'b1, 32'h0000_0010, 4'b0001, 32'h0000_005A, 0, 1, '0, edges, rdata, got);
        check("t4_store_lat", 128'(edges), 128'd1);
        check("t4_dirty_set", 128'(m_dirty[1]), 128'd1);
        do_req(1'b0, 32'hFFFF_FC10, 4'h0, 32'h0, 2, 2, FILL1, edges, rdata, got);
        check("t4_latency",  128'(edges), 128'd7);
        check("t4_wb_seen",  128'(wb_seen), 128'd1);
        check("t4_wb_addr",  128'(wb_addr), 128'h000_0001);
        check("t4_wb_data",  wb_data, 128'hFFEEDDCC_BBAACC88_77665544_3322115A);
        check("t4_rf_addr",  128'(rf_addr), 128'hFFF_FFC1);
        check("t4_rdata",    128'(rdata), 128'h7654_3210);
        check("t4_installs", 128'(n_install), 128'd1);

        // ---- 5: zero-wait memory, clean miss: 1+1+2 = 4 edges ----
        do_req(1'b0, 32'h0000_1234, 4'h0, 32'h0, 0, 1, FILL2, edges, rdata, got);
        check("t5_latency", 128'(edges), 128'd4);
        check("t5_rf_addr", 128'(rf_addr), 128'h000_0123);
        check("t5_no_wb",   128'(wb_seen), 128'd0);
        check("t5_rdata",   128'(rdata), 128'h2222_2222);

        // ---- 6: back-to-back hits with cpu_req held high ----
        cpu_req  = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 32'hFFFF_FC14;
        pulses   = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t6_ready_%0d", k), 128'(cpu_ready), 128'(k % 2));
            if (cpu_ready) begin
                pulses++;
                check($sformatf("t6_rdata_%0d", k), 128'(cpu_rdata), 128'hFEDC_BA98);
            end
        end
        cpu_req = 1'b0;
        check("t6_pulses", 128'(pulses), 128'd4);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
